instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter CENTRE, default 32, home position loaded by reset and by HOME.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, minimum idle cycles between executed instructions (range 1..255).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instruction  input  10  word from the serial receiver, valid while full=1.
REQ-006 SHALL have port full  input  1  receiver flag (level), high when a complete word is held.
REQ-007 SHALL have port rx_clear  output  1  one-cycle pulse telling the receiver its word was consumed.
REQ-008 SHALL have port pos  output  24  four 6-bit servo positions; servo n at pos[6n+5:6n].
REQ-009 SHALL have port upd  output  4  one-cycle strobe per servo whose position was written.
REQ-010 SHALL have port busy  output  1  high when state is not IDLE or a word is pending.
REQ-011 SHALL have port overrun  output  1  sticky flag: a word was dropped.

Function
REQ-012 SHALL register full into full_q; accept event = full & ~full_q at a clock edge E.
REQ-013 SHALL decode op = instruction[9:8], id = instruction[7:6], val = instruction[5:0].
REQ-014 SHALL implement op 00 NOP: no position change, upd=0, still consumed.
REQ-015 SHALL implement op 01 SET: pos[id] <= val.
REQ-016 SHALL implement op 10 STEP: pos[id] <= pos[id] + sign-extended val (two's complement, -32..+31), 7-bit intermediate.
REQ-017 SHALL implement op 11 HOME: all four positions <= CENTRE, upd=4'b1111; id and val ignored.
REQ-018 SHALL use FSM states IDLE, EXEC, HOLD; IDLE->EXEC on accept event or pending word; EXEC->HOLD after one cycle; HOLD->IDLE after HOLD_CYCLES cycles.
REQ-019 SHALL, for an event accepted at edge E while IDLE with nothing pending, latch instruction at E and update pos, assert upd and rx_clear at E+1 (one-cycle latency), each high for exactly one cycle.
REQ-020 SHALL, on an accept event while in EXEC or HOLD with no word pending, copy instruction into a one-entry pending register and execute it from IDLE on the next edge after HOLD ends; rx_clear pulses only when that word executes.
REQ-021 SHALL, on an accept event while a word is already pending, discard the new word, set overrun, and keep the pending word.
REQ-022 SHALL treat an accept event coinciding with the HOLD->IDLE edge as a pending word.
REQ-023 SHALL ignore full held high (no re-execution) until it falls and rises again.
REQ-024 SHALL give pending priority over a simultaneous fresh accept event in IDLE; the fresh event becomes pending.

Reset
REQ-025 SHALL, while reset_n=0, force state IDLE, pos all fields = CENTRE, upd=0, rx_clear=0, busy=0, overrun=0, pending empty, full_q=0.
REQ-026 SHALL, on reset assertion mid-EXEC or mid-HOLD, abandon the word with no upd/rx_clear pulse.
REQ-027 SHALL clear overrun only by reset.

Configuration
REQ-028 SHALL, with macro SEQ_STEP_SAT_EN defined, saturate STEP results to 0..63.
REQ-029 SHALL, without SEQ_STEP_SAT_EN, wrap STEP results modulo 64.

Verification
REQ-030 SHALL cover SET: reset, full rises with 10'b01_10_101010 -> one cycle later pos[17:12]=42, upd=4'b0100, rx_clear=1 for one cycle.
REQ-031 SHALL cover STEP boundary: pos0=60, word 10'b10_00_000111 (+7) -> pos0=63 with SEQ_STEP_SAT_EN, pos0=3 without.
REQ-032 SHALL cover HOME after SETs: word 10'b11_xx_xxxxxx -> all fields=32, upd=4'b1111.
REQ-033 SHALL cover back-to-back: second rising edge of full during HOLD -> executes exactly HOLD_CYCLES+1 cycles after first upd, busy high throughout, overrun=0.
REQ-034 SHALL cover overrun: three rising edges within HOLD -> first and second execute, third dropped, overrun=1 until reset_n low.
REQ-035 SHALL cover async reset mid-HOLD with pending word: reset_n low between edges -> outputs at reset values immediately, pending word never executes.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Receiver-to-sequencer bus for instr_sequencer: instruction word handshake plus
// servo position outputs and status flags.
interface instr_sequencer_if;
  logic [9:0]  instruction;
  logic        full;
  logic        rx_clear;
  logic [23:0] pos;
  logic [3:0]  upd;
  logic        busy;
  logic        overrun;

  modport master (
    output instruction, full,
    input  rx_clear, pos, upd, busy, overrun
  );

  modport slave (
    input  instruction, full,
    output rx_clear, pos, upd, busy, overrun
  );
endinterface

// File: rtl/instr_sequencer.sv
// Servo instruction sequencer: executes NOP/SET/STEP/HOME words from a serial
// receiver with a hold-off between instructions and a one-word pending buffer.
// Optional macro SEQ_STEP_SAT_EN: saturate STEP results to 0..63 instead of wrapping.
module instr_sequencer #(
  parameter int unsigned CENTRE      = 32,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  instr_sequencer_if.slave bus
);

  localparam int unsigned PW     = 6;
  localparam int unsigned NSERVO = 4;
  localparam int unsigned IW     = 10;
  localparam int unsigned CW     = 8;
  localparam int unsigned POSW   = PW * NSERVO;
  localparam logic [PW-1:0] HOME_POS  = PW'(CENTRE);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t            state_q, state_d;
  logic              full_q;
  logic [IW-1:0]     instr_q, instr_d;
  logic              instr_vld_q, instr_vld_d;
  logic [IW-1:0]     pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [POSW-1:0]   pos_q, pos_d;
  logic [NSERVO-1:0] upd_q, upd_d;
  logic              rx_clear_q, rx_clear_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              accept;
  logic              do_exec;
  logic [IW-1:0]     exec_word;

  // Position plus sign-extended 6-bit offset, 7-bit intermediate
  function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] p, input logic [PW-1:0] v);
`ifdef SEQ_STEP_SAT_EN
    logic [PW:0] sum;
    sum = {1'b0, p} + {v[PW-1], v};
    if (sum[PW] && sum[PW-1])
      step_pos = '0;
    else if (sum[PW])
      step_pos = '1;
    else
      step_pos = sum[PW-1:0];
`else
    step_pos = p + v;
`endif
  endfunction

  assign accept = bus.full & ~full_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_vld_d = instr_vld_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    upd_d       = '0;
    rx_clear_d  = 1'b0;
    overrun_d   = overrun_q;
    do_exec     = 1'b0;
    exec_word   = instr_q;

    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          // Pending word was latched long ago, so it executes on this very edge
          exec_word   = pend_q;
          do_exec     = 1'b1;
          pend_vld_d  = 1'b0;
          instr_vld_d = 1'b0;
          state_d     = EXEC;
        end else if (accept) begin
          instr_d     = bus.instruction;
          instr_vld_d = 1'b1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        do_exec     = instr_vld_q;
        instr_vld_d = 1'b0;
        cnt_d       = HOLD_LAST;
        state_d     = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0)
          state_d = IDLE;
        else
          cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Words that cannot start immediately go to the pending slot or are dropped
    if (accept && !(state_q == IDLE && !pend_vld_q)) begin
      if (!pend_vld_q || state_q == IDLE) begin
        pend_d     = bus.instruction;
        pend_vld_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (do_exec) begin
      rx_clear_d = 1'b1;
      case (exec_word[9:8])
        2'b01: begin
          for (int n = 0; n < int'(NSERVO); n++) begin
            if (exec_word[7:6] == 2'(n)) begin
              pos_d[n*PW +: PW] = exec_word[5:0];
              upd_d[n]          = 1'b1;
            end
          end
        end
        2'b10: begin
          for (int n = 0; n < int'(NSERVO); n++) begin
            if (exec_word[7:6] == 2'(n)) begin
              pos_d[n*PW +: PW] = step_pos(pos_q[n*PW +: PW], exec_word[5:0]);
              upd_d[n]          = 1'b1;
            end
          end
        end
        2'b11: begin
          pos_d = {NSERVO{HOME_POS}};
          upd_d = '1;
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE) || pend_vld_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      full_q      <= 1'b0;
      instr_q     <= '0;
      instr_vld_q <= 1'b0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cnt_q       <= '0;
      pos_q       <= {NSERVO{HOME_POS}};
      upd_q       <= '0;
      rx_clear_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= bus.full;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      upd_q       <= upd_d;
      rx_clear_q  <= rx_clear_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.pos      = pos_q;
  assign bus.upd      = upd_q;
  assign bus.rx_clear = rx_clear_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed scenarios plus random words,
// checked against a timing/arithmetic reference model.
module tb_instr_sequencer;
  localparam int H   = 4;
  localparam int CTR = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  instr_sequencer_if bus();

  instr_sequencer #(.CENTRE(CTR), .HOLD_CYCLES(H)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [23:0] pos;
    logic [3:0]  upd;
    int          edge_n;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          mpos[4];
  bit          m_prev_full, m_have_pend, m_over, m_busy, m_acc, m_consumed;
  logic [9:0]  m_pend;
  int          m_ready;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] pack_pos();
    logic [23:0] p;
    for (int n = 0; n < 4; n++) p[n*6 +: 6] = 6'(mpos[n]);
    return p;
  endfunction

  // Apply one word to the model positions and queue the expected response
  task automatic m_exec(input logic [9:0] w, input int edge_n);
    exp_t e;
    int id, v, r;
    id = int'(w[7:6]);
    e.upd = '0;
    case (w[9:8])
      2'b01: begin
        mpos[id] = int'(w[5:0]);
        e.upd[id] = 1'b1;
      end
      2'b10: begin
        v = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
        r = mpos[id] + v;
`ifdef SEQ_STEP_SAT_EN
        if (r < 0) r = 0;
        if (r > 63) r = 63;
`else
        r = (r + 64) % 64;
`endif
        mpos[id] = r;
        e.upd[id] = 1'b1;
      end
      2'b11: begin
        for (int n = 0; n < 4; n++) mpos[n] = CTR;
        e.upd = 4'b1111;
      end
      default: ;
    endcase
    e.pos    = pack_pos();
    e.edge_n = edge_n;
    sbq.push_back(e);
  endtask

  task automatic m_reset();
    sbq.delete();
    for (int n = 0; n < 4; n++) mpos[n] = CTR;
    m_prev_full = 1'b0;
    m_have_pend = 1'b0;
    m_over      = 1'b0;
    m_busy      = 1'b0;
    m_ready     = 0;
  endtask

  // Reference model: executions are spaced by the hold-off; one word may wait
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_reset();
    end else begin
      cyc++;
      m_acc       = bus.full && !m_prev_full;
      m_prev_full = bus.full;
      m_consumed  = 1'b0;
      if (m_have_pend && cyc >= m_ready) begin
        m_exec(m_pend, cyc);
        m_ready     = cyc + H + 2;
        m_have_pend = 1'b0;
        m_consumed  = 1'b1;
      end
      if (m_acc) begin
        if (!m_have_pend && !m_consumed && cyc >= m_ready) begin
          m_exec(bus.instruction, cyc + 1);
          m_ready = cyc + H + 2;
        end else if (!m_have_pend) begin
          m_have_pend = 1'b1;
          m_pend      = bus.instruction;
        end else begin
          m_over = 1'b1;
        end
      end
      m_busy = (cyc < m_ready - 1) || m_have_pend;
    end
  end

  // Monitor: pops an expectation whenever the DUT reports an execution
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.rx_clear || bus.upd != 4'b0) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_exec: upd=%b rx_clear=%b at edge %0d, none required",
                   bus.upd, bus.rx_clear, cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("pos", 32'(bus.pos), 32'(mon_e.pos));
          chk("upd", 32'(bus.upd), 32'(mon_e.upd));
          chk("rx_clear", 32'(bus.rx_clear), 32'd1);
          chk("exec_edge", 32'(cyc), 32'(mon_e.edge_n));
        end
      end else if (sbq.size() > 0 && sbq[0].edge_n <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_exec: nothing at edge %0d, required upd=%b", cyc, sbq[0].upd);
        void'(sbq.pop_front());
      end
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("overrun", 32'(bus.overrun), 32'(m_over));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [9:0] w, input int hi, input int gap);
    bus.instruction = w;
    bus.full        = 1'b1;
    repeat (hi) tick();
    bus.full        = 1'b0;
    bus.instruction = 10'($urandom);
    repeat (gap) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pos"}, 32'(bus.pos), 32'({4{6'd32}}));
    chk({tag, "_upd"}, 32'(bus.upd), 32'd0);
    chk({tag, "_rx_clear"}, 32'(bus.rx_clear), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
  endtask

  initial begin
    bus.full        = 1'b0;
    bus.instruction = '0;
    reset_n         = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // SET servo 2 to 42
    pulse(10'b01_10_101010, 1, H + 4);
    // STEP boundary: 60 + 7
    pulse(10'b01_00_111100, 2, H + 4);
    pulse(10'b10_00_000111, 1, H + 4);
    // SETs then HOME with arbitrary id/val
    pulse(10'b01_01_000101, 1, H + 3);
    pulse(10'b01_11_111111, 1, H + 3);
    pulse({2'b11, 8'($urandom)}, 1, H + 4);
    // full held high must not re-execute; NOP still consumed
    pulse(10'b10_11_111000, 12, H + 4);
    pulse(10'b00_10_110011, 1, H + 4);
    // back-to-back: second word lands during HOLD
    pulse(10'b10_01_000011, 1, 1);
    pulse(10'b10_01_111101, 1, 2 * H + 6);
    // three words inside one HOLD: third dropped
    pulse(10'b01_00_000001, 1, 1);
    pulse(10'b01_01_000010, 1, 1);
    pulse(10'b01_10_000011, 1, 2 * H + 6);
    // async reset mid-HOLD with a word pending
    pulse(10'b01_11_010101, 1, 1);
    pulse(10'b01_11_101010, 1, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (H + 4) tick();

    for (int i = 0; i < 250; i++)
      pulse(10'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, H + 5)));
    repeat (3 * H + 10) tick();

    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d executions outstanding, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
